// File: rtl/reg_wb_ctrl.sv
// Register-file write-back controller: merges load and ALU results into an
// in-order queue and drains it through a registered write port, one per clock.
module reg_wb_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [DATA_W-1:0]       ld_data,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDR_W-1:0]       alu_addr,
  input  logic [DATA_W-1:0]       alu_data,
  input  logic                    wb_hold,
  output logic                    reg_wr,
  output logic [ADDR_W-1:0]       reg_write_addr,
  output logic [DATA_W-1:0]       reg_din,
  input  logic [ADDR_W-1:0]       chk_addr1,
  input  logic [ADDR_W-1:0]       chk_addr2,
  output logic                    chk_busy1,
  output logic                    chk_busy2,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [DEPTH-1:0]  q_vld;

  logic              ld_acc;
  logic              alu_acc;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_next;

  // Readies depend only on registered state and ld_valid; load wins as the older op.
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;
  assign ld_acc    = ld_valid && ld_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign acc_addr  = ld_acc ? ld_addr : alu_addr;
  assign acc_data  = ld_acc ? ld_data : alu_data;

  // Results for x0 complete their handshake but are silently dropped.
  assign push = (ld_acc || alu_acc) && (acc_addr != '0);
  assign pop  = !empty && !wb_hold;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: queue storage has no reset; q_vld and the pointers decide what is live,
  // so leaving the wide data array unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= acc_addr;
      q_data[wr_ptr] <= acc_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      q_vld          <= '0;
      count          <= '0;
      full           <= 1'b0;
      empty          <= 1'b1;
      reg_wr         <= 1'b0;
      reg_write_addr <= '0;
      reg_din        <= '0;
    end else begin
      if (push) begin
        wr_ptr         <= wr_ptr + PTR_W'(1);
        q_vld[wr_ptr]  <= 1'b1;
      end
      if (pop) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        q_vld[rd_ptr]  <= 1'b0;
        reg_write_addr <= q_addr[rd_ptr];
        reg_din        <= q_data[rd_ptr];
      end
      reg_wr <= pop;
      count  <= count_next;
      full   <= (count_next == CNT_W'(DEPTH));
      empty  <= (count_next == '0);
    end
  end

  // Hazard query covers queued entries plus the write currently on the port.
  always_comb begin
    chk_busy1 = reg_wr && (reg_write_addr == chk_addr1);
    chk_busy2 = reg_wr && (reg_write_addr == chk_addr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && (q_addr[i] == chk_addr1)) chk_busy1 = 1'b1;
      if (q_vld[i] && (q_addr[i] == chk_addr2)) chk_busy2 = 1'b1;
    end
    if (chk_addr1 == '0) chk_busy1 = 1'b0;
    if (chk_addr2 == '0) chk_busy2 = 1'b0;
  end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Write-side initiator for the 32x32 register file: collects results from the ALU and the load unit, buffers them in a small in-order queue, and drives the register file write port (reg_wr / reg_write_addr / reg_din), at most one write per clock.
- Also reports whether a given register still has a write pending, so decode can stall on read-after-write hazards.

Parameters:
- DATA_W, 32, data width of a register
- ADDR_W, 5, register address width (32 registers)
- DEPTH, 4, queue entries; power of two, 2..16

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous reset, active-high
- ld_valid  input  1  load unit result valid
- ld_ready  output  1  load result accepted when ld_valid and ld_ready are both high at a clock edge
- ld_addr  input  ADDR_W  load destination register
- ld_data  input  DATA_W  load result
- alu_valid  input  1  ALU result valid
- alu_ready  output  1  ALU result accepted when alu_valid and alu_ready are both high at a clock edge
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- wb_hold  input  1  freezes draining of the queue while high
- reg_wr  output  1  register file write enable, registered
- reg_write_addr  output  ADDR_W  register file write address, registered
- reg_din  output  DATA_W  register file write data, registered
- chk_addr1  input  ADDR_W  first hazard query address
- chk_addr2  input  ADDR_W  second hazard query address
- chk_busy1  output  1  write pending to chk_addr1
- chk_busy2  output  1  write pending to chk_addr2
- count  output  clog2(DEPTH)+1  number of valid queue entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Reset (async, immediate):
  - reg_wr=0, reg_write_addr=0, reg_din=0.
  - count=0, empty=1, full=0; read and write pointers cleared.
  - All queued entries are discarded; a write in flight on reg_wr is dropped in the same instant.
- Ready generation (combinational from registered state only; no same-cycle pass-through):
  - ld_ready = !full.
  - alu_ready = !full && !ld_valid. Load has priority because it is the older instruction.
  - At most one enqueue per cycle.
- Enqueue: the accepted {addr, data} is written at the tail and the tail pointer advances, wrapping modulo DEPTH.
- Address 0:
  - A handshake to address 0 completes normally (ready honoured).
  - The entry is not enqueued and count is unchanged; x0 is never written.
- Drain: at each edge with !empty and !wb_hold:
  - Pop the head entry.
  - Next cycle: reg_wr=1, reg_write_addr=head.addr, reg_din=head.data.
  - Otherwise reg_wr=0 for that cycle; reg_write_addr and reg_din hold their last values.
- Latency: a result accepted at edge N into an empty queue pops at edge N+1. reg_wr is high between edges N+1 and N+2, and the register file commits it at edge N+2.
- Simultaneous enqueue and dequeue: count is unchanged. This is legal even when full=1 only if the enqueue was accepted, which cannot happen because ready is low when full. With a full queue, a pop occurs and ready rises the next cycle.
- Ordering: writes reach the register file in acceptance order. When two queued entries share an address, the later one wins.
- Hazard check (combinational):
  - chk_busyK=1 iff chk_addrK != 0 and the address matches any valid queue entry, or matches reg_write_addr while reg_wr=1.
  - A result being accepted in the current cycle is not included.
- wb_hold=1: the queue fills to DEPTH, then ld_ready and alu_ready go low. Releasing the hold resumes one pop per cycle.
- count, full and empty are registered and consistent with the pointers at all times; pointer wrap-around is exact (extra MSB or counter).

Test Plan:
1. Reset, then ld_valid=1, ld_addr=2, ld_data=0x000000F0 for one cycle -> ld_ready=1 on the acceptance edge; two edges later reg_wr=1, reg_write_addr=2, reg_din=0x000000F0 for exactly one cycle; count returns to 0 and empty=1.
2. ld_valid and alu_valid both high in the same cycle (ld: addr 4, data 0x0F; alu: addr 5, data 0x1234) -> alu_ready=0 that cycle and the load is accepted; the ALU is accepted the next cycle; the register file sees addr 4 first, then addr 5, on consecutive cycles.
3. wb_hold=1 while pushing five ALU results to addrs 1..5 -> after 4 accepts, full=1 and alu_ready=0, and the fifth waits; chk_addr1=3 gives chk_busy1=1. Release the hold -> four writes in order 1,2,3,4, then 5; chk_busy1 falls after the addr-3 write leaves reg_wr.
4. alu_valid with alu_addr=0, data 0xDEADBEEF -> handshake completes, count stays 0, reg_wr never asserts; chk_addr2=0 gives chk_busy2=0.
5. Two entries to addr 7 (0x1 then 0x2) back-to-back -> two writes to addr 7 in order 0x1 then 0x2; chk_busy for addr 7 stays 1 until the second write leaves reg_wr.
6. Assert rst while count=3 and reg_wr=1 -> reg_wr, count and full drop to 0 and empty goes to 1 immediately (asynchronously, before the next edge); after rst is released no stale write appears.
